// File: rtl/mouse_pkg.sv
// mouse_pkg: shared state encoding and PS/2 command/response bytes for the mouse master.
package mouse_pkg;
    typedef logic [3:0] state_t;
    localparam state_t INIT      = 4'd0;
    localparam state_t SEND_RST  = 4'd1;
    localparam state_t WAIT_TX1  = 4'd2;
    localparam state_t WAIT_ACK1 = 4'd3;
    localparam state_t WAIT_BAT  = 4'd4;
    localparam state_t WAIT_ID   = 4'd5;
    localparam state_t SEND_EN   = 4'd6;
    localparam state_t WAIT_TX2  = 4'd7;
    localparam state_t WAIT_ACK2 = 4'd8;
    localparam state_t READ_B1   = 4'd9;
    localparam state_t READ_B2   = 4'd10;
    localparam state_t READ_B3   = 4'd11;
    localparam state_t PUBLISH   = 4'd12;
    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_BAT_OK = 8'hAA;
    localparam logic [7:0] RSP_ID     = 8'h00;
    localparam int CNT_W = 27;
endpackage

// File: rtl/mouse_timeout_counter.sv
// mouse_timeout_counter: saturating cycle counter with two selectable limits and an expired flag.
module mouse_timeout_counter #(
    parameter int unsigned POWERUP_LIMIT = 1_000_000,
    parameter int unsigned RX_LIMIT      = 100_000_000,
    parameter int          W             = 27
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic enable,
    input  logic limit_sel,
    output logic expired
);
    logic [W-1:0] count;
    logic [W-1:0] limit;
    assign limit   = limit_sel ? W'(RX_LIMIT) : W'(POWERUP_LIMIT);
    assign expired = count == limit;
    always_ff @(posedge CLK) begin
        if (RESET || clear) count <= '0;
        else if (enable && !expired) count <= count + W'(1);
    end
endmodule

// File: rtl/mouse_master_sm.sv
// mouse_master_sm: PS/2 mouse init handshake, then 3-byte packet assembly with a
// one-cycle interrupt per published packet.
module mouse_master_sm
    import mouse_pkg::*;
#(
    parameter int unsigned POWERUP_WAIT = 1_000_000,
    parameter int unsigned RX_TIMEOUT   = 100_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    output logic       READ_ENABLE,
    input  logic       BYTE_READY,
    input  logic [7:0] BYTE_RECEIVED,
    input  logic [1:0] BYTE_ERROR_CODE,
    output logic [7:0] MOUSE_STATUS,
    output logic [7:0] MOUSE_DX,
    output logic [7:0] MOUSE_DY,
    output logic       SEND_INTERRUPT,
    output logic       INIT_DONE
);
    state_t     curr_state, next_state;
    logic [7:0] curr_status, curr_dx, curr_dy;
    logic [7:0] next_status, next_dx, next_dy;
    logic       byte_ok, expired, clear;
    assign byte_ok = BYTE_READY && BYTE_ERROR_CODE == 2'b00;
    assign clear   = next_state != curr_state || BYTE_READY || BYTE_SENT;
    mouse_timeout_counter #(
        .POWERUP_LIMIT(POWERUP_WAIT),
        .RX_LIMIT     (RX_TIMEOUT),
        .W            (CNT_W)
    ) u_timer (
        .CLK      (CLK),
        .RESET    (RESET),
        .clear    (clear),
        .enable   (1'b1),
        .limit_sel(curr_state != INIT),
        .expired  (expired)
    );
    always_comb begin
        next_state  = curr_state;
        next_status = curr_status;
        next_dx     = curr_dx;
        next_dy     = curr_dy;
        case (curr_state)
            INIT:      next_state = expired ? SEND_RST : INIT;
            SEND_RST:  next_state = WAIT_TX1;
            WAIT_TX1:  next_state = BYTE_SENT ? WAIT_ACK1 : expired ? INIT : WAIT_TX1;
            WAIT_ACK1: next_state = BYTE_READY ? (byte_ok && BYTE_RECEIVED == RSP_ACK ? WAIT_BAT : INIT)
                                               : expired ? INIT : WAIT_ACK1;
            WAIT_BAT:  next_state = BYTE_READY ? (byte_ok && BYTE_RECEIVED == RSP_BAT_OK ? WAIT_ID : INIT)
                                               : expired ? INIT : WAIT_BAT;
            WAIT_ID:   next_state = BYTE_READY ? (byte_ok && BYTE_RECEIVED == RSP_ID ? SEND_EN : INIT)
                                               : expired ? INIT : WAIT_ID;
            SEND_EN:   next_state = WAIT_TX2;
            WAIT_TX2:  next_state = BYTE_SENT ? WAIT_ACK2 : expired ? INIT : WAIT_TX2;
            WAIT_ACK2: next_state = BYTE_READY ? (byte_ok && BYTE_RECEIVED == RSP_ACK ? READ_B1 : INIT)
                                               : expired ? INIT : WAIT_ACK2;
            // Only a byte with the always-one bit set can start a packet; anything else resyncs here
            READ_B1: if (byte_ok && BYTE_RECEIVED[3]) begin
                next_status = BYTE_RECEIVED;
                next_state  = READ_B2;
            end
            READ_B2: begin
                if (byte_ok) next_dx = BYTE_RECEIVED;
                next_state = BYTE_READY ? (byte_ok ? READ_B3 : READ_B1) : expired ? READ_B1 : READ_B2;
            end
            READ_B3: begin
                if (byte_ok) next_dy = BYTE_RECEIVED;
                next_state = BYTE_READY ? (byte_ok ? PUBLISH : READ_B1) : expired ? READ_B1 : READ_B3;
            end
            PUBLISH:   next_state = READ_B1;
            default:   next_state = INIT;
        endcase
    end
    // Outputs are registered from the state being left/entered so they line up with the new state
    always_ff @(posedge CLK) begin
        if (RESET) begin
            curr_state     <= INIT;
            curr_status    <= '0;
            curr_dx        <= '0;
            curr_dy        <= '0;
            SEND_BYTE      <= 1'b0;
            BYTE_TO_SEND   <= '0;
            READ_ENABLE    <= 1'b0;
            MOUSE_STATUS   <= '0;
            MOUSE_DX       <= '0;
            MOUSE_DY       <= '0;
            SEND_INTERRUPT <= 1'b0;
            INIT_DONE      <= 1'b0;
        end else begin
            curr_state     <= next_state;
            curr_status    <= next_status;
            curr_dx        <= next_dx;
            curr_dy        <= next_dy;
            SEND_BYTE      <= curr_state == SEND_RST || curr_state == SEND_EN;
            BYTE_TO_SEND   <= curr_state == SEND_RST ? CMD_RESET : curr_state == SEND_EN ? CMD_ENABLE : BYTE_TO_SEND;
            READ_ENABLE    <= !(next_state inside {INIT, SEND_RST, WAIT_TX1, SEND_EN, WAIT_TX2});
            INIT_DONE      <= next_state inside {READ_B1, READ_B2, READ_B3, PUBLISH};
            SEND_INTERRUPT <= curr_state == PUBLISH;
            if (curr_state == PUBLISH) begin
                MOUSE_STATUS <= curr_status;
                MOUSE_DX     <= curr_dx;
                MOUSE_DY     <= curr_dy;
            end
        end
    end
endmodule

// File: tb/tb_mouse_master_sm.sv
// tb_mouse_master_sm: directed bench with a byte-level packet model checked every cycle.
module tb_mouse_master_sm;
    localparam int PW = 10;
    localparam int RX = 1000;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       BYTE_SENT = 1'b0;
    logic       READ_ENABLE;
    logic       BYTE_READY = 1'b0;
    logic [7:0] BYTE_RECEIVED = 8'h00;
    logic [1:0] BYTE_ERROR_CODE = 2'b00;
    logic [7:0] MOUSE_STATUS, MOUSE_DX, MOUSE_DY;
    logic       SEND_INTERRUPT;
    logic       INIT_DONE;

    mouse_master_sm #(.POWERUP_WAIT(PW), .RX_TIMEOUT(RX)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .SEND_BYTE      (SEND_BYTE),
        .BYTE_TO_SEND   (BYTE_TO_SEND),
        .BYTE_SENT      (BYTE_SENT),
        .READ_ENABLE    (READ_ENABLE),
        .BYTE_READY     (BYTE_READY),
        .BYTE_RECEIVED  (BYTE_RECEIVED),
        .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
        .MOUSE_STATUS   (MOUSE_STATUS),
        .MOUSE_DX       (MOUSE_DX),
        .MOUSE_DY       (MOUSE_DY),
        .SEND_INTERRUPT (SEND_INTERRUPT),
        .INIT_DONE      (INIT_DONE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;
    int rst_edge = 0;
    int last_edge = 0;
    bit chk_on = 1'b0;
    bit streaming = 1'b0;

    // Packet model: bytes accepted so far, expected outputs and the edge that publishes them
    logic [7:0] q[$];
    int         q_edge = 0;
    int         pub_edge = -1;
    logic [7:0] pend_st = 0, pend_dx = 0, pend_dy = 0;
    logic [7:0] exp_st = 0, exp_dx = 0, exp_dy = 0;
    logic       exp_irq = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_byte(input logic [7:0] b, input logic [1:0] err, input int e);
        if (q.size() > 0 && e - q_edge > RX + 1) q.delete();
        if (err != 2'b00) q.delete();
        else if (q.size() > 0 || b[3]) begin
            q.push_back(b);
            q_edge = e;
            if (q.size() == 3) begin
                pend_st  = q[0];
                pend_dx  = q[1];
                pend_dy  = q[2];
                pub_edge = e + 1;
                q.delete();
            end
        end
    endtask

    always @(negedge CLK) if (chk_on) begin
        if (cyc == pub_edge) begin
            exp_st  = pend_st;
            exp_dx  = pend_dx;
            exp_dy  = pend_dy;
            exp_irq = 1'b1;
        end else exp_irq = 1'b0;
        chk("irq", 32'(SEND_INTERRUPT), 32'(exp_irq));
        chk("packet", 32'({MOUSE_STATUS, MOUSE_DX, MOUSE_DY}), 32'({exp_st, exp_dx, exp_dy}));
    end

    task automatic do_reset();
        @(posedge CLK); #1 RESET = 1'b1;
        @(posedge CLK); #1 RESET = 1'b0;
        rst_edge  = cyc;
        streaming = 1'b0;
        q.delete();
        pub_edge = -1;
        exp_st = 0; exp_dx = 0; exp_dy = 0;
    endtask

    task automatic feed(input logic [7:0] b, input logic [1:0] err);
        @(posedge CLK); #1;
        BYTE_READY = 1'b1; BYTE_RECEIVED = b; BYTE_ERROR_CODE = err;
        @(posedge CLK); #1;
        last_edge = cyc;
        BYTE_READY = 1'b0; BYTE_ERROR_CODE = 2'b00;
        if (streaming) model_byte(b, err, last_edge);
    endtask

    task automatic tx_done();
        @(posedge CLK); #1 BYTE_SENT = 1'b1;
        @(posedge CLK); #1 BYTE_SENT = 1'b0;
        last_edge = cyc;
    endtask

    task automatic wait_send(input string name, input logic [7:0] b, input int at);
        int n = 0;
        do begin @(negedge CLK); n++; end while (!SEND_BYTE && n < 2000);
        chk({name, " when"}, 32'(cyc), 32'(at));
        chk({name, " byte"}, 32'(BYTE_TO_SEND), 32'(b));
        chk({name, " rx off"}, 32'(READ_ENABLE), 0);
        @(negedge CLK);
        chk({name, " one cycle"}, 32'(SEND_BYTE), 0);
        chk({name, " held"}, 32'(BYTE_TO_SEND), 32'(b));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " send"}, 32'(SEND_BYTE), 0);
        chk({name, " cmd"}, 32'(BYTE_TO_SEND), 0);
        chk({name, " rx en"}, 32'(READ_ENABLE), 0);
        chk({name, " pkt"}, 32'({MOUSE_STATUS, MOUSE_DX, MOUSE_DY}), 0);
        chk({name, " irq"}, 32'(SEND_INTERRUPT), 0);
        chk({name, " done"}, 32'(INIT_DONE), 0);
    endtask

    task automatic init_seq(input string name);
        wait_send({name, " reset cmd"}, 8'hFF, rst_edge + 12);
        tx_done();
        @(negedge CLK);
        chk({name, " rx on ack1"}, 32'(READ_ENABLE), 1);
        feed(8'hFA, 2'b00);
        feed(8'hAA, 2'b00);
        feed(8'h00, 2'b00);
        wait_send({name, " enable cmd"}, 8'hF4, last_edge + 1);
        tx_done();
        feed(8'hFA, 2'b00);
        @(negedge CLK);
        chk({name, " init done"}, 32'(INIT_DONE), 1);
        chk({name, " rx on stream"}, 32'(READ_ENABLE), 1);
        streaming = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        do_reset();
        chk_on = 1'b1;
        @(negedge CLK);
        chk_all_zero("reset");
        init_seq("boot");

        feed(8'h08, 2'b00);
        feed(8'h05, 2'b00);
        feed(8'hFB, 2'b00);
        @(negedge CLK);
        chk("pkt1 not yet", 32'(SEND_INTERRUPT), 0);
        @(negedge CLK);
        chk("pkt1 value", 32'({MOUSE_STATUS, MOUSE_DX, MOUSE_DY}), 32'h0805FB);
        chk("pkt1 irq", 32'(SEND_INTERRUPT), 1);
        @(negedge CLK);
        chk("pkt1 irq drop", 32'(SEND_INTERRUPT), 0);

        feed(8'h00, 2'b00);
        feed(8'h09, 2'b00);
        feed(8'h12, 2'b01);
        @(negedge CLK);
        chk("resync keeps dx", 32'(MOUSE_DX), 32'h05);
        chk("resync done", 32'(INIT_DONE), 1);
        feed(8'h08, 2'b10);
        feed(8'h18, 2'b00);
        feed(8'h01, 2'b00);
        feed(8'h02, 2'b00);
        repeat (2) @(negedge CLK);
        chk("pkt2 value", 32'({MOUSE_STATUS, MOUSE_DX, MOUSE_DY}), 32'h180102);

        feed(8'h09, 2'b00);
        repeat (1100) @(negedge CLK);
        feed(8'h33, 2'b00);
        feed(8'h0C, 2'b00);
        feed(8'h07, 2'b00);
        feed(8'h08, 2'b00);
        repeat (2) @(negedge CLK);
        chk("b2 timeout pkt", 32'({MOUSE_STATUS, MOUSE_DX, MOUSE_DY}), 32'h0C0708);

        feed(8'h28, 2'b00);
        feed(8'h11, 2'b00);
        do_reset();
        @(negedge CLK);
        chk_all_zero("mid reset");
        wait_send("restart", 8'hFF, rst_edge + 12);

        tx_done();
        feed(8'hFA, 2'b00);
        feed(8'hAB, 2'b00);
        @(negedge CLK);
        chk("bad bat rx off", 32'(READ_ENABLE), 0);
        chk("bad bat not done", 32'(INIT_DONE), 0);
        wait_send("bad bat retry", 8'hFF, last_edge + 12);

        wait_send("tx timeout retry", 8'hFF, last_edge + 12 + RX + 13);
        @(negedge CLK);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
